// File: rtl/render_pkg.sv
// Shared types for the shape renderer frame sequencer: shape kinds, scheduler
// states and the shape descriptor layout used by the shape table.
package render_pkg;

  localparam int CORDW_DEFAULT  = 10;
  localparam int DATAW_DEFAULT  = 12;
  localparam int NSHAPE_DEFAULT = 7;
  localparam int IDXW_DEFAULT   = 3;

  // Only squares exist today; the remaining encodings are reserved.
  typedef enum logic [DATAW_DEFAULT-1:0] {
    SHAPE_SQUARE = '0
  } shape_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } sched_state_e;

  typedef struct packed {
    logic [DATAW_DEFAULT-1:0] ty;
    logic [CORDW_DEFAULT-1:0] x0;
    logic [CORDW_DEFAULT-1:0] y0;
    logic [DATAW_DEFAULT-1:0] size;
  } shape_desc_t;

endpackage

// File: rtl/render_sched_watchdog.sv
// Per-shape cycle watchdog for render_scheduler; only instantiated when
// RENDER_SCHED_WATCHDOG_EN is defined.
module render_sched_watchdog #(
  parameter int TIMEOUT = 1048576
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            CW    = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Counts enabled cycles and parks at LIMIT, so the TIMEOUT-th cycle expires.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/render_scheduler.sv
// Frame-level sequencer walking the shape table and handing each drawable entry
// to the renderer. Optional per-shape watchdog: RENDER_SCHED_WATCHDOG_EN.
module render_scheduler
  import render_pkg::*;
#(
  parameter int CORDW   = CORDW_DEFAULT,
  parameter int DATAW   = DATAW_DEFAULT,
  parameter int NSHAPE  = NSHAPE_DEFAULT,
  parameter int IDXW    = IDXW_DEFAULT,
  parameter int TIMEOUT = 1048576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  output logic [IDXW-1:0]  shp_addr,
  input  logic             shp_valid,
  input  logic [DATAW-1:0] shp_ty,
  input  logic [CORDW-1:0] shp_x0,
  input  logic [CORDW-1:0] shp_y0,
  input  logic [DATAW-1:0] shp_size,
  output logic             r_start,
  output logic [DATAW-1:0] r_ty,
  output logic [CORDW-1:0] r_x0,
  output logic [CORDW-1:0] r_y0,
  output logic [DATAW-1:0] r_size,
  input  logic             r_done,
  output logic             busy,
  output logic             frame_done,
  output logic [IDXW:0]    drawn_cnt,
  output logic             err
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSHAPE - 1);
  localparam logic [IDXW:0]   CNT_MAX  = (IDXW + 1)'(NSHAPE);

  if ((2 ** IDXW) < NSHAPE) begin : g_bad_idxw
    $error("render_scheduler: IDXW too narrow for NSHAPE");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("render_scheduler: TIMEOUT must be positive");
  end

  sched_state_e     state_q;
  logic [IDXW-1:0]  shp_addr_q;
  logic             r_start_q;
  logic [DATAW-1:0] r_ty_q;
  logic [CORDW-1:0] r_x0_q;
  logic [CORDW-1:0] r_y0_q;
  logic [DATAW-1:0] r_size_q;
  logic             busy_q;
  logic             frame_done_q;
  logic [IDXW:0]    drawn_cnt_q;

`ifdef RENDER_SCHED_WATCHDOG_EN
  logic err_q;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  // The count restarts as the shape is issued, i.e. on the way into WAIT.
  assign wd_clear  = (state_q == S_ISSUE);
  assign wd_enable = (state_q == S_WAIT);

  render_sched_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shp_addr_q   <= '0;
      r_start_q    <= 1'b0;
      r_ty_q       <= '0;
      r_x0_q       <= '0;
      r_y0_q       <= '0;
      r_size_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      drawn_cnt_q  <= '0;
`ifdef RENDER_SCHED_WATCHDOG_EN
      err_q        <= 1'b0;
`endif
    end else begin
      r_start_q    <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            shp_addr_q  <= '0;
            drawn_cnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        // Table data for shp_addr_q is valid now; empty or disabled entries are skipped.
        S_LOAD: begin
          r_ty_q   <= shp_ty;
          r_x0_q   <= shp_x0;
          r_y0_q   <= shp_y0;
          r_size_q <= shp_size;
          if (shp_valid && (shp_size != '0)) begin
            state_q <= S_ISSUE;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_ISSUE: begin
          r_start_q <= 1'b1;
          if (drawn_cnt_q != CNT_MAX) begin
            drawn_cnt_q <= drawn_cnt_q + (IDXW + 1)'(1);
          end
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (r_done) begin
            state_q <= S_NEXT;
          end
`ifdef RENDER_SCHED_WATCHDOG_EN
          else if (wd_expired) begin
            err_q   <= 1'b1;
            state_q <= S_NEXT;
          end
`endif
        end
        S_NEXT: begin
          if (shp_addr_q == LAST_IDX) begin
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            shp_addr_q <= shp_addr_q + IDXW'(1);
            state_q    <= S_FETCH;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign shp_addr   = shp_addr_q;
  assign r_start    = r_start_q;
  assign r_ty       = r_ty_q;
  assign r_x0       = r_x0_q;
  assign r_y0       = r_y0_q;
  assign r_size     = r_size_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign drawn_cnt  = drawn_cnt_q;

endmodule
